id_ex_stage: RTL and testbench

ID/EX pipeline stage of the five-stage MIPS core. It registers decoded operands and control from ID and resolves data hazards: EX/MEM and MEM/WB forwarding, plus load-use interlock with bubble insertion. It drives the operand and function inputs of the EX-stage ALU directly. ALU operands are combinational functions of the stage register and the forwarding buses; no extra cycle is added.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/id_ex_stage_if.sv | 32 +++
 rtl/fwd_mux.sv | 41 ++++
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline slice: register and data
// widths, ALU function codes, forwarding-source encoding, the ID/EX slot
// layout and the forwarding match helper.
package mips_pkg;

  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int ALU_F_W = 4;

  localparam logic [ALU_F_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_F_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_F_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_F_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_F_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_F_W-1:0] ALU_NOR  = 4'b0101;
  localparam logic [ALU_F_W-1:0] ALU_SLT  = 4'b0110;
  localparam logic [ALU_F_W-1:0] ALU_SLTU = 4'b0111;
  localparam logic [ALU_F_W-1:0] ALU_SLL  = 4'b1000;
  localparam logic [ALU_F_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [ALU_F_W-1:0] ALU_SRA  = 4'b1010;
  localparam logic [ALU_F_W-1:0] ALU_SLLV = 4'b1011;
  localparam logic [ALU_F_W-1:0] ALU_SRLV = 4'b1100;
  localparam logic [ALU_F_W-1:0] ALU_SRAV = 4'b1101;
  localparam logic [ALU_F_W-1:0] ALU_LUI  = 4'b1110;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // Contents of the EX slot held between ID and EX.
  typedef struct packed {
    logic                valid;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    shamt;
    logic [ALU_F_W-1:0]  f;
    logic                alu_src;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   imm;
  } ex_slot_t;

  // True when a writing stage targets src; $0 is never a producer.
  function automatic logic src_match(input logic we,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] src);
    return we && (rd != {REG_W{1'b0}}) && (rd == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX handshake bundle: decoded operands, control and valid/ready.
interface id_ex_stage_if;
  import mips_pkg::*;

  logic               valid;
  logic               ready;
  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic [DATA_W-1:0]  imm;
  logic [REG_W-1:0]   rs;
  logic [REG_W-1:0]   rt;
  logic [REG_W-1:0]   rd;
  logic [REG_W-1:0]   shamt;
  logic [ALU_F_W-1:0] alu_f;
  logic               alu_src;
  logic               reg_write;
  logic               mem_read;
  logic               mem_write;

  modport master (
    output valid, rs_data, rt_data, imm, rs, rt, rd, shamt, alu_f,
           alu_src, reg_write, mem_read, mem_write,
    input  ready
  );

  modport slave (
    input  valid, rs_data, rt_data, imm, rs, rt, rd, shamt, alu_f,
           alu_src, reg_write, mem_read, mem_write,
    output ready
  );

endinterface

// File: rtl/fwd_mux.sv
// Per-operand forwarding mux: compares a source register number against the
// EX/MEM and MEM/WB writers and selects the newest value. Without forwarding
// the same comparator doubles as the RAW hazard detector in id_ex_stage.
module fwd_mux
  import mips_pkg::*;
(
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_we,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_we,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] data,
  output fwd_sel_t          sel
);

  // Source select; the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    sel = FWD_NONE;
    if (src_match(exmem_we, exmem_rd, src)) begin
      sel = FWD_EXMEM;
    end else if (src_match(memwb_we, memwb_rd, src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_NONE;
    end
  end

  // Data steering driven by the select.
  always_comb begin
    data = reg_data;
    case (sel)
      FWD_EXMEM: data = exmem_data;
      FWD_MEMWB: data = memwb_data;
      default:   data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers the decoded instruction, forwards EX/MEM
// and MEM/WB results into the ALU operands and interlocks on load-use.
// Optional feature macro: ID_EX_FORWARD_EN. When undefined, forwarding is
// removed and the stage stalls on any RAW hazard against EX or EX/MEM.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  id_ex_stage_if.slave       id_bus,
  input  logic               flush,
  input  logic               freeze,
  input  logic               exmem_reg_write,
  input  logic [REG_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0]  exmem_result,
  input  logic               memwb_reg_write,
  input  logic [REG_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0]  memwb_result,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [ALU_F_W-1:0] alu_f,
  output logic [REG_W-1:0]   alu_shamt,
  output logic               ex_valid,
  output logic [REG_W-1:0]   ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic               load_use_stall
);

  ex_slot_t          slot_r;
  logic              stall_s;
  logic [DATA_W-1:0] rs_fwd_s;
  logic [DATA_W-1:0] rt_fwd_s;

`ifdef ID_EX_FORWARD_EN
  fwd_sel_t rs_sel_s;
  fwd_sel_t rt_sel_s;
  logic     unused_fwd_sel_s;

  fwd_mux u_fwd_rs (
    .src        (slot_r.rs),
    .reg_data   (slot_r.rs_data),
    .exmem_we   (exmem_reg_write),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_result),
    .memwb_we   (memwb_reg_write),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_result),
    .data       (rs_fwd_s),
    .sel        (rs_sel_s)
  );

  fwd_mux u_fwd_rt (
    .src        (slot_r.rt),
    .reg_data   (slot_r.rt_data),
    .exmem_we   (exmem_reg_write),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_result),
    .memwb_we   (memwb_reg_write),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_result),
    .data       (rt_fwd_s),
    .sel        (rt_sel_s)
  );

  assign unused_fwd_sel_s = ^{rs_sel_s, rt_sel_s};

  // Load-use: a load in EX cannot feed the instruction waiting in ID.
  always_comb begin
    stall_s = id_bus.valid && slot_r.valid && slot_r.mem_read &&
              (slot_r.rd != 5'd0) &&
              ((slot_r.rd == id_bus.rs) || (slot_r.rd == id_bus.rt));
  end
`else
  fwd_sel_t          rs_haz_sel_s;
  fwd_sel_t          rt_haz_sel_s;
  logic [DATA_W-1:0] rs_haz_data_s;
  logic [DATA_W-1:0] rt_haz_data_s;
  logic              unused_nofwd_s;

  // The EX slot and EX/MEM are the in-flight writers; MEM/WB is covered by
  // the register file writing before it is read.
  fwd_mux u_haz_rs (
    .src        (id_bus.rs),
    .reg_data   (32'h0000_0000),
    .exmem_we   (slot_r.valid & slot_r.reg_write),
    .exmem_rd   (slot_r.rd),
    .exmem_data (32'h0000_0000),
    .memwb_we   (exmem_reg_write),
    .memwb_rd   (exmem_rd),
    .memwb_data (32'h0000_0000),
    .data       (rs_haz_data_s),
    .sel        (rs_haz_sel_s)
  );

  fwd_mux u_haz_rt (
    .src        (id_bus.rt),
    .reg_data   (32'h0000_0000),
    .exmem_we   (slot_r.valid & slot_r.reg_write),
    .exmem_rd   (slot_r.rd),
    .exmem_data (32'h0000_0000),
    .memwb_we   (exmem_reg_write),
    .memwb_rd   (exmem_rd),
    .memwb_data (32'h0000_0000),
    .data       (rt_haz_data_s),
    .sel        (rt_haz_sel_s)
  );

  assign rs_fwd_s = slot_r.rs_data;
  assign rt_fwd_s = slot_r.rt_data;
  assign unused_nofwd_s = ^{rs_haz_data_s, rt_haz_data_s, exmem_result,
                            memwb_reg_write, memwb_rd, memwb_result,
                            slot_r.rs, slot_r.rt};

  // Any RAW hazard against an in-flight writer holds ID until it retires.
  always_comb begin
    stall_s = id_bus.valid &&
              ((rs_haz_sel_s != FWD_NONE) || (rt_haz_sel_s != FWD_NONE));
  end
`endif

  // Stage register: freeze holds, flush/stall/idle drain, else capture ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r <= '0;
    end else if (freeze) begin
      slot_r <= slot_r;
    end else if (flush || stall_s || !id_bus.valid) begin
      slot_r.valid     <= 1'b0;
      slot_r.reg_write <= 1'b0;
      slot_r.mem_read  <= 1'b0;
      slot_r.mem_write <= 1'b0;
    end else begin
      slot_r <= '{valid:     1'b1,
                  rs:        id_bus.rs,
                  rt:        id_bus.rt,
                  rd:        id_bus.rd,
                  shamt:     id_bus.shamt,
                  f:         id_bus.alu_f,
                  alu_src:   id_bus.alu_src,
                  reg_write: id_bus.reg_write,
                  mem_read:  id_bus.mem_read,
                  mem_write: id_bus.mem_write,
                  rs_data:   id_bus.rs_data,
                  rt_data:   id_bus.rt_data,
                  imm:       id_bus.imm};
    end
  end

  // ALU operands and EX control; control is gated so a bubble never writes.
  always_comb begin
    alu_a          = rs_fwd_s;
    alu_b          = slot_r.alu_src ? slot_r.imm : rt_fwd_s;
    alu_f          = slot_r.f;
    alu_shamt      = slot_r.shamt;
    ex_store_data  = rt_fwd_s;
    ex_valid       = slot_r.valid;
    ex_rd          = slot_r.valid ? slot_r.rd : 5'd0;
    ex_reg_write   = slot_r.valid & slot_r.reg_write;
    ex_mem_read    = slot_r.valid & slot_r.mem_read;
    ex_mem_write   = slot_r.valid & slot_r.mem_write;
    load_use_stall = stall_s;
    id_bus.ready   = !freeze && !stall_s;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table-driven operand/forwarding
// vectors through a scoreboard queue, then hand-written hazard, flush,
// freeze and reset sequences. Expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        freeze = 1'b0;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_f;
  logic [4:0]  alu_shamt, ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        load_use_stall;
  int          checks = 0;
  int          errors = 0;

  id_ex_stage_if id_bus();

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_bus(id_bus), .flush(flush), .freeze(freeze),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_shamt(alu_shamt),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] rsd, rtd, imm;
    logic [3:0]  f;
    logic        src, rw, mr, mw;
    logic        xw; logic [4:0] xrd; logic [31:0] xres;
    logic        ww; logic [4:0] wrd; logic [31:0] wres;
    logic [31:0] fa, fb, fsd;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, sd;
    logic [3:0]  f;
    logic [4:0]  sh, rd;
    logic        rw, mr, mw;
  } exp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle_buses();
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [3:0] f, input logic [4:0] sh,
                          input logic src, input logic rw, input logic mr, input logic mw);
    id_bus.valid = v; id_bus.rs = rs; id_bus.rt = rt; id_bus.rd = rd;
    id_bus.rs_data = rsd; id_bus.rt_data = rtd; id_bus.imm = imm;
    id_bus.alu_f = f; id_bus.shamt = sh; id_bus.alu_src = src;
    id_bus.reg_write = rw; id_bus.mem_read = mr; id_bus.mem_write = mw;
  endtask

  task automatic drive_none();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, ALU_ADD, 5'd0,
             1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Producer writes $3 at cycle 0; it is in EX/MEM at cycle 2, MEM/WB at 3.
  task automatic set_buses(input int c, input logic [31:0] ex_val, input logic [31:0] wb_val);
    idle_buses();
    if (c == 2) begin
      exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = ex_val;
    end
    if (c == 3) begin
      memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = wb_val;
    end
  endtask

  // Producer of $3 followed by a dependent add $4,$3,$3 held in ID.
  task automatic raw_seq(input string nm, input logic ld, input logic [31:0] ex_val,
                         input logic [31:0] wb_val, input int exp_stalls);
    int          stalls = 0;
    int          c = 1;
    logic        done = 1'b0;
    logic [31:0] dep;
    idle_buses();
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h7, 32'h9, 32'h4, ALU_ADD, 5'd0,
             ld, 1'b1, ld, 1'b0);
    tick();
    while (!done && c < 8) begin
      set_buses(c, ex_val, wb_val);
      dep = (c >= 3) ? wb_val : 32'h0000_0BAD;
      drive_id(1'b1, 5'd3, 5'd3, 5'd4, dep, dep, 32'h0, ALU_ADD, 5'd0,
               1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      if (ld && c == 2) chk({nm, "_bubble_valid"}, ex_valid, 1'b0);
      if (id_bus.ready) done = 1'b1;
      else stalls++;
      tick();
      c++;
    end
    chk({nm, "_accepted"}, done, 1'b1);
    chk({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    drive_none();
    set_buses(c, ex_val, wb_val);
    #1;
    chk({nm, "_ex_valid"}, ex_valid, 1'b1);
    chk({nm, "_alu_a"}, alu_a, wb_val);
    chk({nm, "_alu_b"}, alu_b, wb_val);
    chk({nm, "_ex_rd"}, ex_rd, 5'd4);
    tick();
    idle_buses();
  endtask

  initial begin
    vec_t vecs[8];
    exp_t q[$];
    exp_t e;

    // rs rt rd sh | rsd rtd imm | f src rw mr mw | exmem | memwb | fwd a b sd
    vecs[0] = '{5'd3, 5'd5, 5'd4, 5'd0, 32'h1111, 32'h5, 32'h0, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd3, 32'h10, 1'b0, 5'd0, 32'h0, 32'h10, 32'h5, 32'h5};
    vecs[1] = '{5'd3, 5'd6, 5'd7, 5'd0, 32'h1111, 32'h66, 32'h0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20, 32'h10, 32'h66, 32'h66};
    vecs[2] = '{5'd0, 5'd2, 5'd8, 5'd0, 32'h0, 32'h22, 32'h0, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77, 32'h0, 32'h22, 32'h22};
    vecs[3] = '{5'd1, 5'd9, 5'd11, 5'd0, 32'h100, 32'h900, 32'h0, ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd10, 32'hAA, 1'b1, 5'd9, 32'h99, 32'h100, 32'h99, 32'h99};
    vecs[4] = '{5'd2, 5'd3, 5'd0, 5'd0, 32'h200, 32'h300, 32'h8, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1,
                1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 32'h200, 32'h8, 32'h33};
    vecs[5] = '{5'd4, 5'd12, 5'd13, 5'd0, 32'h400, 32'hC00, 32'hFFFF_FFFC, ALU_SLT, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b0, 5'd4, 32'h44, 1'b1, 5'd4, 32'h45, 32'h45, 32'hFFFF_FFFC, 32'hC00};
    vecs[6] = '{5'd0, 5'd7, 5'd14, 5'd5, 32'h0, 32'h3, 32'h0, ALU_SLL, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h3, 32'h3};
    vecs[7] = '{5'd5, 5'd5, 5'd15, 5'd0, 32'h500, 32'h500, 32'h0, ALU_XOR, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd5, 32'hE1, 1'b1, 5'd5, 32'hE2, 32'hE1, 32'hE1, 32'hE1};

    // Reset state
    idle_buses();
    drive_none();
    #12;
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_store_data", ex_store_data, 32'h0);
    chk("rst_ex_rd", ex_rd, 5'd0);
    chk("rst_alu_f", alu_f, 4'd0);
    chk("rst_stall", load_use_stall, 1'b0);
    chk("rst_id_ready", id_bus.ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table vectors: push expectation on issue, pop when the slot is valid
    for (int i = 0; i < 8; i++) begin
      idle_buses();
      drive_id(1'b1, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rsd, vecs[i].rtd,
               vecs[i].imm, vecs[i].f, vecs[i].sh, vecs[i].src, vecs[i].rw,
               vecs[i].mr, vecs[i].mw);
      #1;
      chk($sformatf("v%0d_id_ready", i), id_bus.ready, 1'b1);
`ifdef ID_EX_FORWARD_EN
      e.a = vecs[i].fa; e.b = vecs[i].fb; e.sd = vecs[i].fsd;
`else
      e.a = vecs[i].rsd; e.b = vecs[i].src ? vecs[i].imm : vecs[i].rtd; e.sd = vecs[i].rtd;
`endif
      e.f = vecs[i].f; e.sh = vecs[i].sh; e.rd = vecs[i].rd;
      e.rw = vecs[i].rw; e.mr = vecs[i].mr; e.mw = vecs[i].mw;
      q.push_back(e);
      tick();
      drive_none();
      exmem_reg_write = vecs[i].xw; exmem_rd = vecs[i].xrd; exmem_result = vecs[i].xres;
      memwb_reg_write = vecs[i].ww; memwb_rd = vecs[i].wrd; memwb_result = vecs[i].wres;
      #1;
      chk($sformatf("v%0d_ex_valid", i), ex_valid, 1'b1);
      if (ex_valid === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("v%0d_alu_a", i), alu_a, e.a);
        chk($sformatf("v%0d_alu_b", i), alu_b, e.b);
        chk($sformatf("v%0d_store", i), ex_store_data, e.sd);
        chk($sformatf("v%0d_alu_f", i), alu_f, e.f);
        chk($sformatf("v%0d_shamt", i), alu_shamt, e.sh);
        chk($sformatf("v%0d_ex_rd", i), ex_rd, e.rd);
        chk($sformatf("v%0d_ctrl", i), {ex_reg_write, ex_mem_read, ex_mem_write},
            {e.rw, e.mr, e.mw});
      end
      tick();
    end
    chk("queue_drained", 32'(q.size()), 32'd0);

    // Dependent add after add / after load
`ifdef ID_EX_FORWARD_EN
    raw_seq("alu_raw", 1'b0, 32'h10, 32'h10, 0);
    raw_seq("load_use", 1'b1, 32'h40, 32'hDEAD, 1);
`else
    raw_seq("alu_raw", 1'b0, 32'h10, 32'h10, 2);
    raw_seq("load_use", 1'b1, 32'h40, 32'hDEAD, 2);
`endif

    // Flush squashes the incoming instruction
    idle_buses();
    drive_id(1'b1, 5'd1, 5'd2, 5'd10, 32'hA1, 32'hA2, 32'h0, ALU_ADD, 5'd0,
             1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_flush_valid", ex_valid, 1'b1);
    flush = 1'b1;
    drive_id(1'b1, 5'd1, 5'd2, 5'd11, 32'hB1, 32'hB2, 32'h0, ALU_ADD, 5'd0,
             1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    drive_none();
    #1;
    chk("flush_ex_valid", ex_valid, 1'b0);
    chk("flush_reg_write", ex_reg_write, 1'b0);
    chk("flush_ex_rd", ex_rd, 5'd0);
    tick();

    // Freeze for three edges, with a flush in the middle
    drive_id(1'b1, 5'd6, 5'd7, 5'd12, 32'hC6, 32'hC7, 32'h0, ALU_SUB, 5'd4,
             1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    freeze = 1'b1;
    drive_id(1'b1, 5'd13, 5'd14, 5'd15, 32'hD1, 32'hD2, 32'h0, ALU_OR, 5'd0,
             1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("frz%0d_id_ready", k), id_bus.ready, 1'b0);
      chk($sformatf("frz%0d_ex_valid", k), ex_valid, 1'b1);
      chk($sformatf("frz%0d_alu_a", k), alu_a, 32'hC6);
      chk($sformatf("frz%0d_alu_b", k), alu_b, 32'hC7);
      chk($sformatf("frz%0d_ex_rd", k), ex_rd, 5'd12);
      chk($sformatf("frz%0d_shamt", k), alu_shamt, 5'd4);
      if (k < 3) begin
        flush = (k == 1);
        tick();
        flush = 1'b0;
      end
    end
    freeze = 1'b0;
    drive_none();
    tick();

    // Reset during a load-use stall
    drive_id(1'b1, 5'd1, 5'd5, 5'd5, 32'h100, 32'h0, 32'h4, ALU_ADD, 5'd0,
             1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd5, 5'd5, 5'd6, 32'h1, 32'h1, 32'h0, ALU_ADD, 5'd0,
             1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("pre_rst_stall", load_use_stall, 1'b1);
    chk("pre_rst_ready", id_bus.ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", load_use_stall, 1'b0);
    chk("mid_rst_ready", id_bus.ready, 1'b1);
    chk("mid_rst_ex_valid", ex_valid, 1'b0);
    chk("mid_rst_alu_a", alu_a, 32'h0);
    chk("mid_rst_ex_rd", ex_rd, 5'd0);
    chk("mid_rst_mem_read", ex_mem_read, 1'b0);
    #2;
    rst_n = 1'b1;
    drive_none();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
